// File: rtl/insn_fetch_unit_pkg.sv
// ============================================================================
//  Module   : insn_fetch_unit_pkg
//  Brief    : Shared types and constants for the instruction-fetch stage.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package insn_fetch_unit_pkg;

   localparam int c_INSN_ADDR_WIDTH = 32;
   localparam int c_INSN_WIDTH      = 32;
   localparam int c_DEFAULT_PC_STEP = 4;

   typedef logic [c_INSN_ADDR_WIDTH-1:0] insn_addr_t;
   typedef logic [c_INSN_WIDTH-1:0]      insn_t;

   typedef enum logic [1:0] {
      FETCH_RESET = 2'd0,
      FETCH       = 2'd1,
      HOLD        = 2'd2,
      DROP        = 2'd3
   } fetch_state_t;

   // Redirect targets are word aligned; the low two address bits are ignored.
   function automatic insn_addr_t align_target(input insn_addr_t t);
      return t & ~insn_addr_t'(2'b11);
   endfunction

endpackage

`default_nettype wire

// File: rtl/insn_fetch_unit_if.sv
// ============================================================================
//  Module   : insn_fetch_unit_if
//  Brief    : Instruction-memory req/ack bus between the fetch stage and imem.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface insn_fetch_unit_if;
   import insn_fetch_unit_pkg::*;

   logic       imemReq;
   insn_addr_t imemAddr;
   logic       imemAck;
   insn_t      imemData;

   modport master (
      output imemReq,
      output imemAddr,
      input  imemAck,
      input  imemData
   );

   modport slave (
      input  imemReq,
      input  imemAddr,
      output imemAck,
      output imemData
   );

endinterface

`default_nettype wire

// File: rtl/insn_fetch_unit_hold_buf.sv
// ============================================================================
//  Module   : fetch_hold_buf
//  Brief    : One-entry {pc, insn} holding register with load and clear.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_hold_buf
   import insn_fetch_unit_pkg::*;
(
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       i_load,
   input  wire logic       i_clear,
   input  wire insn_addr_t i_pc,
   input  wire insn_t      i_insn,
   output insn_addr_t      o_pc,
   output insn_t           o_insn
);

   insn_addr_t r_pc;
   insn_t      r_insn;

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_pc   <= '0;
         r_insn <= '0;
      end else if (i_load) begin
         r_pc   <= i_pc;
         r_insn <= i_insn;
      end
   end

   assign o_pc   = r_pc;
   assign o_insn = r_insn;

endmodule

`default_nettype wire

// File: rtl/insn_fetch_unit.sv
// ============================================================================
//  Module   : insn_fetch_unit
//  Brief    : IF stage: owns the PC, fetches over req/ack, honours stall/flush.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module insn_fetch_unit
   import insn_fetch_unit_pkg::*;
#(
   parameter insn_addr_t RESET_PC = '0,
   parameter insn_addr_t PC_STEP  = insn_addr_t'(c_DEFAULT_PC_STEP)
)(
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              dHazard,
   input  wire logic              cHazard,
   input  wire insn_addr_t        brTarget,
   insn_fetch_unit_if.master      imem,
   output insn_addr_t             PCAddrOut,
   output insn_t                  InsnOut
);

   fetch_state_t r_state, w_state_nxt;
   insn_addr_t   r_pc, w_pc_nxt;
   insn_addr_t   r_drop_addr, w_drop_addr_nxt;

   logic         w_hold_load, w_hold_clear;
   insn_addr_t   w_hold_pc;
   insn_t        w_hold_insn;
   insn_addr_t   w_target;

   logic         w_req;
   insn_addr_t   w_addr;
   insn_addr_t   w_pc_out;
   insn_t        w_insn_out;

   assign w_target = align_target(brTarget);

   fetch_hold_buf u_hold (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_hold_load),
      .i_clear (w_hold_clear),
      .i_pc    (r_pc),
      .i_insn  (imem.imemData),
      .o_pc    (w_hold_pc),
      .o_insn  (w_hold_insn)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= FETCH_RESET;
         r_pc        <= RESET_PC;
         r_drop_addr <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_drop_addr <= w_drop_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_drop_addr_nxt = r_drop_addr;
      w_hold_load     = 1'b0;
      w_hold_clear    = 1'b0;
      w_req           = 1'b0;
      w_addr          = r_pc;
      w_pc_out        = '0;
      w_insn_out      = '0;

      case (r_state)
         FETCH_RESET: begin
            w_state_nxt = FETCH;
         end
         FETCH: begin
            w_req = 1'b1;
            if (imem.imemAck) begin
               w_pc_out   = r_pc;
               w_insn_out = imem.imemData;
            end
            if (cHazard) begin
               w_pc_nxt = w_target;
               // An unacked request cannot be withdrawn; finish it in DROP.
               if (!imem.imemAck) begin
                  w_state_nxt     = DROP;
                  w_drop_addr_nxt = r_pc;
               end
            end else if (imem.imemAck) begin
               if (dHazard) begin
                  w_hold_load = 1'b1;
                  w_state_nxt = HOLD;
               end else begin
                  w_pc_nxt = r_pc + PC_STEP;
               end
            end
         end
         HOLD: begin
            w_pc_out   = w_hold_pc;
            w_insn_out = w_hold_insn;
            if (cHazard) begin
               w_hold_clear = 1'b1;
               w_pc_nxt     = w_target;
               w_state_nxt  = FETCH;
            end else if (!dHazard) begin
               w_hold_clear = 1'b1;
               w_pc_nxt     = r_pc + PC_STEP;
               w_state_nxt  = FETCH;
            end
         end
         DROP: begin
            w_req  = 1'b1;
            w_addr = r_drop_addr;
            if (cHazard) begin
               w_pc_nxt = w_target;
            end
            if (imem.imemAck) begin
               w_state_nxt = FETCH;
            end
         end
         default: begin
            w_state_nxt = FETCH_RESET;
         end
      endcase

      // Reset forces a bubble and no request regardless of the current state.
      if (rst) begin
         w_req      = 1'b0;
         w_pc_out   = '0;
         w_insn_out = '0;
      end
   end

   assign imem.imemReq  = w_req;
   assign imem.imemAddr = w_addr;
   assign PCAddrOut     = w_pc_out;
   assign InsnOut       = w_insn_out;

endmodule

`default_nettype wire

// File: tb/tb_insn_fetch_unit.sv
// ============================================================================
//  Module   : tb_insn_fetch_unit
//  Brief    : Self-checking bench for insn_fetch_unit with a behavioural model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_insn_fetch_unit;
   import insn_fetch_unit_pkg::*;

   localparam logic [31:0] c_K = 32'hA5A5_0000;

   logic       clk = 1'b0;
   logic       rst;
   logic       dHazard;
   logic       cHazard;
   insn_addr_t brTarget;
   insn_addr_t PCAddrOut;
   insn_t      InsnOut;

   insn_fetch_unit_if u_if();

   insn_fetch_unit #(
      .RESET_PC (32'h0),
      .PC_STEP  (32'd4)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .dHazard   (dHazard),
      .cHazard   (cHazard),
      .brTarget  (brTarget),
      .imem      (u_if.master),
      .PCAddrOut (PCAddrOut),
      .InsnOut   (InsnOut)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int mem_left = 0;
   int cfg_wait = 0;
   bit rand_mode = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, answer the memory, then settle at the negedge.
   task automatic step(input logic r, input logic dh, input logic ch, input logic [31:0] bt);
      @(posedge clk);
      #1;
      rst = r; dHazard = dh; cHazard = ch; brTarget = bt;
      #1;
      if (r || !u_if.imemReq) begin
         u_if.imemAck  = 1'b0;
         u_if.imemData = $urandom;
         if (r) mem_left = cfg_wait;
      end else if (mem_left == 0) begin
         u_if.imemAck  = 1'b1;
         u_if.imemData = u_if.imemAddr ^ c_K;
         if (rand_mode) cfg_wait = $urandom_range(0, 2);
         mem_left = cfg_wait;
      end else begin
         u_if.imemAck  = 1'b0;
         u_if.imemData = $urandom;
         mem_left--;
      end
      @(negedge clk);
   endtask

   // Reference model: what the stage should present, derived from pc, an
   // optional held instruction and an optional request being discarded.
   initial begin : model
      bit         m_boot = 1'b1;
      insn_addr_t m_pc = '0;
      bit         m_has_hold = 1'b0;
      insn_addr_t m_hold_pc = '0;
      insn_t      m_hold_insn = '0;
      bit         m_discard = 1'b0;
      insn_addr_t m_stale = '0;
      logic        e_req;
      logic [31:0] e_addr, e_pc, e_insn, tgt;
      forever begin
         @(negedge clk);
         e_addr = '0;
         if (rst || m_boot) begin
            e_req = 1'b0; e_pc = '0; e_insn = '0;
         end else if (m_has_hold) begin
            e_req = 1'b0; e_pc = m_hold_pc; e_insn = m_hold_insn;
         end else if (m_discard) begin
            e_req = 1'b1; e_addr = m_stale; e_pc = '0; e_insn = '0;
         end else begin
            e_req = 1'b1; e_addr = m_pc;
            e_pc   = u_if.imemAck ? m_pc : '0;
            e_insn = u_if.imemAck ? (m_pc ^ c_K) : '0;
         end
         chk("model_req", {31'b0, u_if.imemReq}, {31'b0, e_req});
         if (e_req) chk("model_addr", u_if.imemAddr, e_addr);
         chk("model_pc", PCAddrOut, e_pc);
         chk("model_insn", InsnOut, e_insn);

         tgt = {brTarget[31:2], 2'b00};
         if (rst) begin
            m_boot = 1'b1; m_pc = '0; m_has_hold = 1'b0; m_discard = 1'b0;
         end else if (m_boot) begin
            m_boot = 1'b0;
         end else if (m_has_hold) begin
            if (cHazard)       begin m_has_hold = 1'b0; m_pc = tgt; end
            else if (!dHazard) begin m_has_hold = 1'b0; m_pc = m_pc + 32'd4; end
         end else if (m_discard) begin
            if (cHazard) m_pc = tgt;
            if (u_if.imemAck) m_discard = 1'b0;
         end else if (cHazard) begin
            if (!u_if.imemAck) begin m_discard = 1'b1; m_stale = m_pc; end
            m_pc = tgt;
         end else if (u_if.imemAck) begin
            if (dHazard) begin
               m_has_hold = 1'b1; m_hold_pc = m_pc; m_hold_insn = m_pc ^ c_K;
            end else begin
               m_pc = m_pc + 32'd4;
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : driver
      rst = 1'b1; dHazard = 1'b0; cHazard = 1'b0; brTarget = '0;
      u_if.imemAck = 1'b0; u_if.imemData = '0;

      // Reset, then zero-wait streaming from address 0.
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("t1_reset_req", {31'b0, u_if.imemReq}, 32'd0);
      chk("t1_reset_pc", PCAddrOut, 32'd0);
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 0, 0);
         chk("t1_pc_seq", PCAddrOut, 32'(4 * k));
      end
      chk("t1_insn12", InsnOut, 32'hA5A5_000C);

      // Two wait states after reset.
      cfg_wait = 2;
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      cfg_wait = 0;
      for (int k = 0; k < 2; k++) begin
         step(0, 0, 0, 0);
         chk("t2_bubble_pc", PCAddrOut, 32'd0);
         chk("t2_bubble_insn", InsnOut, 32'd0);
         chk("t2_addr", u_if.imemAddr, 32'd0);
      end
      step(0, 0, 0, 0);
      chk("t2_data", InsnOut, 32'hA5A5_0000);

      // Stall on the instruction at 8.
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      chk("t3_ack_pc", PCAddrOut, 32'd8);
      for (int k = 0; k < 3; k++) begin
         step(0, (k < 2) ? 1'b1 : 1'b0, 0, 0);
         chk("t3_hold_pc", PCAddrOut, 32'd8);
         chk("t3_hold_insn", InsnOut, 32'hA5A5_0008);
         chk("t3_hold_req", {31'b0, u_if.imemReq}, 32'd0);
      end
      cfg_wait = 3;
      step(0, 0, 0, 0);
      chk("t3_next_addr", u_if.imemAddr, 32'd12);

      // Flush while the request for 0x10 is outstanding.
      step(0, 0, 1, 32'h103);
      chk("t4_pending_addr", u_if.imemAddr, 32'h10);
      for (int k = 0; k < 3; k++) begin
         if (k == 2) cfg_wait = 0;
         step(0, 0, 0, 0);
         chk("t4_drop_addr", u_if.imemAddr, 32'h10);
         chk("t4_drop_insn", InsnOut, 32'd0);
      end
      step(0, 1, 0, 0);
      chk("t4_redirect_addr", u_if.imemAddr, 32'h100);

      // Flush and stall together while holding.
      step(0, 1, 1, 32'h200);
      chk("t5_hold_pc", PCAddrOut, 32'h100);
      step(0, 0, 0, 0);
      chk("t5_redirect_addr", u_if.imemAddr, 32'h200);

      // PC wrap, then reset while discarding.
      step(0, 0, 1, 32'hFFFF_FFFF);
      step(0, 0, 0, 0);
      chk("t6_top_pc", PCAddrOut, 32'hFFFF_FFFC);
      cfg_wait = 3;
      step(0, 0, 0, 0);
      chk("t6_wrap_addr", u_if.imemAddr, 32'd0);
      step(0, 0, 1, 32'h40);
      step(0, 0, 0, 0);
      chk("t6_drop_req", {31'b0, u_if.imemReq}, 32'd1);
      chk("t6_drop_addr", u_if.imemAddr, 32'd4);
      cfg_wait = 0;
      step(1, 0, 0, 0);
      chk("t6_rst_req", {31'b0, u_if.imemReq}, 32'd0);
      chk("t6_rst_insn", InsnOut, 32'd0);
      step(0, 0, 0, 0);
      chk("t6_resetstate_req", {31'b0, u_if.imemReq}, 32'd0);
      step(0, 0, 0, 0);
      chk("t6_restart_addr", u_if.imemAddr, 32'd0);
      chk("t6_restart_pc", PCAddrOut, 32'd0);

      // Randomized traffic checked by the model.
      rand_mode = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 9) < 3),
              ($urandom_range(0, 9) == 0),
              $urandom);
      end
      step(0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
